// File: rtl/bt_frame_parser_p.sv
// ============================================================================
// Module   : bt_frame_parser_p
// Purpose  : Decodes tagged ASCII frames from a UART byte stream into
//            per-field ASCII digit slots. Optional BT_PARSER_CHECKSUM_EN adds
//            a trailing XOR checksum byte.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module bt_frame_parser_p #(
    parameter int                NF          = 4,
    parameter int                MAXD        = 6,
    parameter logic [NF*8-1:0]   TAGS        = "AEHI",
    parameter logic [NF*4-1:0]   DIGITS      = 16'h3361,
    parameter int                TIMEOUT_CYC = 5_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_done_tick,
    input  logic [7:0]             rx_data,
    output logic [NF*MAXD*8-1:0]   fields_o,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [2:0]             err_code,
    output logic [7:0]             err_count,
    output logic                   busy
);

    localparam int              SW   = MAXD * 8;
    localparam int              IW   = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SW-1:0]   FILL = {MAXD{8'h30}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FIELD_DATA = 3'd1,
        S_FIELD_TAG  = 3'd2,
`ifdef BT_PARSER_CHECKSUM_EN
        S_CHK        = 3'd3,
`endif
        S_COMMIT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         dcnt_q, dcnt_d;
    logic [SW-1:0]      shadow_q [NF];
    logic [SW-1:0]      shadow_d [NF];
    logic [NF*SW-1:0]   fields_q, fields_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [2:0]         code_q, code_d;
    logic [7:0]         ecnt_q, ecnt_d;
`ifdef BT_PARSER_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
`endif

    logic [7:0]         tag_w    [NF];
    logic [3:0]         digits_w [NF];
    logic               w_active;
    logic               w_timeout;
    logic               w_is_digit;
    logic               w_idle_rules;
    logic               w_abort;
    logic [2:0]         w_abort_code;

    // Field 0 lives in the most-significant byte/nibble of the tables.
    for (genvar g = 0; g < NF; g++) begin : g_tab
        assign tag_w[g]    = TAGS[(NF-1-g)*8 +: 8];
        assign digits_w[g] = DIGITS[(NF-1-g)*4 +: 4];
    end

`ifdef BT_PARSER_CHECKSUM_EN
    assign w_active = (state_q == S_FIELD_DATA) || (state_q == S_FIELD_TAG) ||
                      (state_q == S_CHK);
`else
    assign w_active = (state_q == S_FIELD_DATA) || (state_q == S_FIELD_TAG);
`endif

    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    if (TIMEOUT_CYC > 0) begin : g_tmo
        localparam int CW = $clog2(TIMEOUT_CYC + 1);
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (rx_done_tick || !w_active) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign w_timeout = w_active && (cnt_q == CW'(TIMEOUT_CYC));
    end else begin : g_no_tmo
        assign w_timeout = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dcnt_d       = dcnt_q;
        shadow_d     = shadow_q;
        fields_d     = fields_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        code_d       = code_q;
        ecnt_d       = ecnt_q;
`ifdef BT_PARSER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        w_idle_rules = 1'b0;
        w_abort      = 1'b0;
        w_abort_code = 3'd0;

        case (state_q)
            S_IDLE: begin
                w_idle_rules = 1'b1;
            end

            S_COMMIT: begin
                for (int k = 0; k < NF; k++) begin
                    fields_d[k*SW +: SW] = shadow_q[k];
                end
                valid_d      = 1'b1;
                w_idle_rules = 1'b1;
            end

            S_FIELD_DATA: begin
                if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_abort_code = 3'd3;
                    w_idle_rules = 1'b1;
                end else if (rx_done_tick) begin
                    if (w_is_digit) begin
                        shadow_d[idx_q] = (shadow_q[idx_q] << 8) | SW'(rx_data);
                        dcnt_d          = dcnt_q + 4'd1;
`ifdef BT_PARSER_CHECKSUM_EN
                        xor_d           = xor_q ^ rx_data;
`endif
                        if (dcnt_q + 4'd1 == digits_w[idx_q]) begin
                            dcnt_d = 4'd0;
                            if (idx_q == IW'(NF - 1)) begin
`ifdef BT_PARSER_CHECKSUM_EN
                                state_d = S_CHK;
`else
                                state_d = S_COMMIT;
`endif
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = S_FIELD_TAG;
                            end
                        end
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = 3'd2;
                        w_idle_rules = 1'b1;
                    end
                end
            end

            S_FIELD_TAG: begin
                if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_abort_code = 3'd3;
                    w_idle_rules = 1'b1;
                end else if (rx_done_tick) begin
                    if (rx_data == tag_w[idx_q]) begin
                        state_d = S_FIELD_DATA;
`ifdef BT_PARSER_CHECKSUM_EN
                        xor_d   = xor_q ^ rx_data;
`endif
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = 3'd1;
                        w_idle_rules = 1'b1;
                    end
                end
            end

`ifdef BT_PARSER_CHECKSUM_EN
            S_CHK: begin
                if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_abort_code = 3'd3;
                    w_idle_rules = 1'b1;
                end else if (rx_done_tick) begin
                    if (rx_data == xor_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        w_abort      = 1'b1;
                        w_abort_code = 3'd4;
                        w_idle_rules = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_abort) begin
            err_d  = 1'b1;
            code_d = w_abort_code;
            if (ecnt_q != 8'hFF) begin
                ecnt_d = ecnt_q + 8'd1;
            end
        end

        // Idle rules also cover the resync byte of an abort and a tick landing in COMMIT.
        if (w_idle_rules) begin
            state_d = S_IDLE;
            if (rx_done_tick && (rx_data == tag_w[0])) begin
                state_d = S_FIELD_DATA;
                idx_d   = '0;
                dcnt_d  = 4'd0;
                for (int k = 0; k < NF; k++) begin
                    shadow_d[k] = FILL;
                end
`ifdef BT_PARSER_CHECKSUM_EN
                xor_d   = rx_data;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            dcnt_q   <= 4'd0;
            fields_q <= {NF{FILL}};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 3'd0;
            ecnt_q   <= 8'd0;
            for (int k = 0; k < NF; k++) begin
                shadow_q[k] <= FILL;
            end
`ifdef BT_PARSER_CHECKSUM_EN
            xor_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dcnt_q   <= dcnt_d;
            fields_q <= fields_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ecnt_q   <= ecnt_d;
            shadow_q <= shadow_d;
`ifdef BT_PARSER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign fields_o    = fields_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;
    assign err_count   = ecnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bt_frame_parser_p.sv
// ============================================================================
// Module   : tb_bt_frame_parser_p
// Purpose  : Self-checking bench for bt_frame_parser_p (vector table + event scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bt_frame_parser_p;

    localparam int NF   = 4;
    localparam int MAXD = 6;
    localparam int FW   = NF * MAXD * 8;
    localparam int TMO  = 100;
    localparam int FLEN = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_done_tick = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [FW-1:0] fields_o;
    logic          frame_valid;
    logic          frame_err;
    logic [2:0]    err_code;
    logic [7:0]    err_count;
    logic          busy;

    bt_frame_parser_p #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .fields_o     (fields_o),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [2:0]    code;
        logic [7:0]    cnt;
        logic [FW-1:0] fields;
    } ev_t;

    typedef struct {
        string         s;
        logic [2:0]    err;
        bit            ok;
        logic [FW-1:0] f;
        int            gap;
    } vec_t;

    ev_t           sb[$];
    vec_t          vecs[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [FW-1:0] m_fields;
    logic [2:0]    m_code;
    logic [7:0]    m_cnt;

    function automatic logic [FW-1:0] mk(string f0, string f1, string f2, string f3);
        string         a[4];
        logic [FW-1:0] r;
        a[0] = f0; a[1] = f1; a[2] = f2; a[3] = f3;
        r = {(NF*MAXD){8'h30}};
        for (int k = 0; k < NF; k++) begin
            for (int j = 0; j < a[k].len(); j++) begin
                r[k*MAXD*8 + j*8 +: 8] = a[k].getc(a[k].len() - 1 - j);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xor_tail(string s);
        logic [7:0] x = 8'h00;
        for (int i = s.len() - FLEN; i < s.len(); i++) begin
            x = x ^ s.getc(i);
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_err(input logic [2:0] code);
        ev_t e;
        m_code = code;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e.is_err = 1'b1; e.code = m_code; e.cnt = m_cnt; e.fields = m_fields;
        sb.push_back(e);
    endtask

    task automatic push_ok(input logic [FW-1:0] f);
        ev_t e;
        m_fields = f;
        e.is_err = 1'b0; e.code = m_code; e.cnt = m_cnt; e.fields = m_fields;
        sb.push_back(e);
    endtask

    // Called aligned to a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s.getc(i));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", FW'(sb.size()), FW'(0));
    endtask

    task automatic run_vec(input vec_t v);
        if (v.err != 3'd0) push_err(v.err);
        if (v.ok) push_ok(v.f);
        send_str(v.s);
`ifdef BT_PARSER_CHECKSUM_EN
        if (v.ok) send_byte(xor_tail(v.s));
`endif
        idle(v.gap);
        if (v.gap >= 3) wait_drain(10);
    endtask

    task automatic add_vec(input string s, input logic [2:0] err, input bit ok,
                           input logic [FW-1:0] f, input int gap);
        vec_t v;
        v.s = s; v.err = err; v.ok = ok; v.f = f; v.gap = gap;
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (frame_valid || frame_err)) begin
            chk("valid_err_exclusive", FW'(frame_valid & frame_err), FW'(0));
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: valid=%0b err=%0b code=%0d, required no event",
                         frame_valid, frame_err, err_code);
            end else begin
                e = sb.pop_front();
                chk("event_kind",  FW'(frame_err), FW'(e.is_err));
                chk("err_code",    FW'(err_code),  FW'(e.code));
                chk("err_count",   FW'(err_count), FW'(e.cnt));
                chk("fields",      fields_o,       e.fields);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] zero_f;
        zero_f   = mk("", "", "", "");
        m_fields = zero_f;
        m_code   = 3'd0;
        m_cnt    = 8'd0;

        add_vec("A123E045H235959I2",    3'd0, 1'b1, mk("123", "045", "235959", "2"), 0);
        add_vec("A999E000H000001I9",    3'd0, 1'b1, mk("999", "000", "000001", "9"), 4);
        add_vec("A1x2",                 3'd2, 1'b0, zero_f, 4);
        add_vec("A321E540H959532I7",    3'd0, 1'b1, mk("321", "540", "959532", "7"), 4);
        add_vec("A12A123E045H235959I2", 3'd2, 1'b1, mk("123", "045", "235959", "2"), 4);
        add_vec("A123X",                3'd1, 1'b0, zero_f, 4);
        add_vec("A123E045H235959Q",     3'd1, 1'b0, zero_f, 4);
        add_vec("ZZ7A000E999H999999I0", 3'd0, 1'b1, mk("000", "999", "999999", "0"), 4);

        idle(3);
        chk("reset_fields",  fields_o,             zero_f);
        chk("reset_valid",   FW'(frame_valid),     FW'(0));
        chk("reset_err",     FW'(frame_err),       FW'(0));
        chk("reset_code",    FW'(err_code),        FW'(0));
        chk("reset_count",   FW'(err_count),       FW'(0));
        chk("reset_busy",    FW'(busy),            FW'(0));
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Inter-byte timeout mid-frame, then a stray byte in IDLE.
        push_err(3'd3);
        send_str("A123E");
        idle(90);
        chk("busy_before_timeout", FW'(busy), FW'(1));
        wait_drain(40);
        chk("timeout_busy", FW'(busy),     FW'(0));
        chk("timeout_code", FW'(err_code), FW'(3));
        send_byte("E");
        idle(5);
        chk("stray_byte_count", FW'(err_count), FW'(m_cnt));
        chk("stray_byte_busy",  FW'(busy),      FW'(0));

`ifdef BT_PARSER_CHECKSUM_EN
        push_ok(mk("111", "222", "333333", "4"));
        send_str("A111E222H333333I4");
        send_byte(xor_tail("A111E222H333333I4"));
        idle(4);
        push_err(3'd4);
        send_str("A555E666H777777I8");
        send_byte(xor_tail("A555E666H777777I8") ^ 8'h01);
        idle(4);
        wait_drain(10);
        chk("chk_bad_fields", fields_o, mk("111", "222", "333333", "4"));
`endif

        // Reset in the middle of a frame.
        send_str("A123E04");
        rst_n = 1'b0;
        #1;
        chk("midrst_fields", fields_o,         zero_f);
        chk("midrst_busy",   FW'(busy),        FW'(0));
        chk("midrst_count",  FW'(err_count),   FW'(0));
        chk("midrst_code",   FW'(err_code),    FW'(0));
        chk("midrst_valid",  FW'(frame_valid), FW'(0));
        m_fields = zero_f;
        m_code   = 3'd0;
        m_cnt    = 8'd0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 257 tag bytes: each one after the first aborts and resyncs.
        for (int i = 0; i < 256; i++) push_err(3'd2);
        for (int i = 0; i < 257; i++) send_byte("A");
        push_ok(mk("123", "045", "235959", "2"));
        send_str("123E045H235959I2");
`ifdef BT_PARSER_CHECKSUM_EN
        send_byte(xor_tail("A123E045H235959I2"));
`endif
        idle(4);
        wait_drain(20);
        chk("sat_count", FW'(err_count), FW'(255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
